// File: rtl/snake_ctrl_if.sv
// rtl/snake_ctrl_if.sv - button, food, pixel-scan and status bundle for snake_ctrl
interface snake_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [7:0] food_X;
    logic [7:0] food_Y;
    logic [7:0] c_pixel;
    logic [7:0] r_pixel;
    logic       gen_food;
    logic       game_over;
    logic       snake_prnt;
    logic [7:0] head_X;
    logic [7:0] head_Y;
    logic [7:0] score;

    modport master (
        output btn_up, btn_down, btn_left, btn_right,
        output food_X, food_Y, c_pixel, r_pixel,
        input  gen_food, game_over, snake_prnt, head_X, head_Y, score
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right,
        input  food_X, food_Y, c_pixel, r_pixel,
        output gen_food, game_over, snake_prnt, head_X, head_Y, score
    );
endinterface

// File: rtl/snake_ctrl.sv
// rtl/snake_ctrl.sv - snake body shift register, move timing, eat/collision detection
module snake_ctrl #(
    parameter int         MAX_LEN  = 16,
    parameter int         INIT_LEN = 3,
    parameter int         MOVE_DIV = 2500000,
    parameter logic [7:0] START_X  = 8'h30,
    parameter logic [7:0] START_Y  = 8'h40
) (
    input  logic         clk,
    input  logic         rst,
    snake_ctrl_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, EAT, OVER} state_t;
    // Encoding chosen so the reverse of a direction is just bit 0 flipped.
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t        state, state_nxt;
    dir_t          dir, req;
    logic          req_vld;
    logic [CW-1:0] cnt;
    logic [LW-1:0] len, lim;
    logic [7:0]    seg_x [MAX_LEN];
    logic [7:0]    seg_y [MAX_LEN];
    logic [7:0]    score_r;
    logic [7:0]    nxt_x, nxt_y;
    logic          active, move, grow, legal, self_hit, collide;

    always_comb begin
        req_vld = 1'b1;
        req     = D_RIGHT;
        if (bus.btn_up)         req = D_UP;
        else if (bus.btn_down)  req = D_DOWN;
        else if (bus.btn_left)  req = D_LEFT;
        else if (bus.btn_right) req = D_RIGHT;
        else                    req_vld = 1'b0;
    end

    always_comb begin
        nxt_x = seg_x[0];
        nxt_y = seg_y[0];
        case (dir)
            D_UP:    nxt_y = seg_y[0] - 8'd1;
            D_DOWN:  nxt_y = seg_y[0] + 8'd1;
            D_LEFT:  nxt_x = seg_x[0] - 8'd1;
            default: nxt_x = seg_x[0] + 8'd1;
        endcase
    end

    assign active = (state == RUN) || (state == EAT);
    assign move   = active && (cnt == CW'(MOVE_DIV - 1));
    assign grow   = ({nxt_x, nxt_y} == {bus.food_X, bus.food_Y});
    assign legal  = (nxt_x >= 8'h10) && (nxt_x <= 8'h90) && (nxt_y >= 8'h0A) && (nxt_y <= 8'h6E);

    // The tail vacates on a plain move, so it only blocks the head when growing.
    always_comb begin
        lim      = grow ? len : len - 1'b1;
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < lim && seg_x[i] == nxt_x && seg_y[i] == nxt_y)
                self_hit = 1'b1;
    end

    assign collide = !legal || self_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_vld) state_nxt = RUN;
            RUN, EAT: begin
                if (move)             state_nxt = collide ? OVER : (grow ? EAT : RUN);
                else if (state == EAT) state_nxt = RUN;
            end
            default: state_nxt = OVER;
        endcase
    end

    always_comb begin
        bus.gen_food  = (state == EAT);
        bus.game_over = (state == OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir     <= D_RIGHT;
            cnt     <= '0;
            len     <= LW'(INIT_LEN);
            score_r <= 8'd0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? START_X - 8'(i) : START_X;
                seg_y[i] <= START_Y;
            end
        end else begin
            if (state != OVER && req_vld && req != dir_t'(dir ^ 2'b01))
                dir <= req;
            cnt <= active ? (move ? '0 : cnt + 1'b1) : '0;
            if (move && !collide) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nxt_x;
                seg_y[0] <= nxt_y;
                if (grow) begin
                    if (len != LW'(MAX_LEN)) len <= len + 1'b1;
                    if (score_r != 8'hFF)    score_r <= score_r + 8'd1;
                end
            end
        end
    end

    always_comb begin
        bus.snake_prnt = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < len && seg_x[i] == bus.c_pixel && seg_y[i] == bus.r_pixel)
                bus.snake_prnt = 1'b1;
    end

    assign bus.head_X = seg_x[0];
    assign bus.head_Y = seg_y[0];
    assign bus.score  = score_r;
endmodule

// File: tb/tb_snake_ctrl.sv
// tb/tb_snake_ctrl.sv - directed self-checking bench for snake_ctrl
module tb_snake_ctrl;
    localparam int MD = 4;
    localparam int B_NONE = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   gf;
    logic [15:0] exp_q [$];

    snake_ctrl_if bus ();

    snake_ctrl #(.MOVE_DIV(MD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pix(input string tag, input logic [7:0] c, input logic [7:0] r, input logic expv);
        bus.c_pixel = c;
        bus.r_pixel = r;
        #1;
        chk(tag, {31'd0, bus.snake_prnt}, {31'd0, expv});
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_UP:    bus.btn_up    = v;
            B_DOWN:  bus.btn_down  = v;
            B_LEFT:  bus.btn_left  = v;
            B_RIGHT: bus.btn_right = v;
            default: ;
        endcase
    endtask

    task automatic chk_head(input string tag, input logic [7:0] ex, input logic [7:0] ey);
        chk({tag, "_x"}, {24'd0, bus.head_X}, {24'd0, ex});
        chk({tag, "_y"}, {24'd0, bus.head_Y}, {24'd0, ey});
    endtask

    // Called right after a move edge; spans one move period and returns how
    // many sampled cycles had gen_food high.
    task automatic run_move(input logic [7:0] ex, input logic [7:0] ey, input int b, output int gfc);
        logic [15:0] e;
        exp_q.push_back({ex, ey});
        gfc = 0;
        set_btn(b, 1'b1);
        step(1);
        if (bus.gen_food) gfc++;
        set_btn(b, 1'b0);
        repeat (MD - 1) begin
            step(1);
            if (bus.gen_food) gfc++;
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk_head("move_head", e[15:8], e[7:0]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_head(tag, 8'h30, 8'h40);
        chk({tag, "_over"},  {31'd0, bus.game_over}, 32'd0);
        chk({tag, "_gen"},   {31'd0, bus.gen_food},  32'd0);
        chk({tag, "_score"}, {24'd0, bus.score},     32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
        bus.food_X = 8'h80; bus.food_Y = 8'h60;
        bus.c_pixel = 8'h00; bus.r_pixel = 8'h00;
        step(2);
        rst = 1'b0;
        step(1);

        chk_reset_vals("rst");
        pix("rst_prnt_2f", 8'h2F, 8'h40, 1'b1);
        pix("rst_prnt_2e", 8'h2E, 8'h40, 1'b1);
        pix("rst_prnt_2d", 8'h2D, 8'h40, 1'b0);

        // Start: one-cycle right press enters RUN; first move 4 cycles later.
        bus.btn_right = 1'b1;
        step(1);
        bus.btn_right = 1'b0;
        step(MD - 1);
        chk_head("pre_move", 8'h30, 8'h40);
        step(1);
        chk_head("first_move", 8'h31, 8'h40);
        pix("tail_vacated", 8'h2E, 8'h40, 1'b0);
        pix("tail_new", 8'h30, 8'h40, 1'b1);

        // Holding the reverse direction is ignored; up takes effect next move.
        bus.btn_left = 1'b1;
        run_move(8'h32, 8'h40, B_NONE, gf);
        bus.btn_left = 1'b0;
        run_move(8'h32, 8'h3F, B_UP, gf);

        // Eat at (33,3F): single gen_food pulse, score 1, length 4.
        bus.food_X = 8'h33; bus.food_Y = 8'h3F;
        run_move(8'h33, 8'h3F, B_RIGHT, gf);
        chk("eat_gen_now", {31'd0, bus.gen_food}, 32'd1);
        chk("eat_score", {24'd0, bus.score}, 32'd1);
        pix("len4_tail", 8'h31, 8'h40, 1'b1);
        bus.food_X = 8'h35; bus.food_Y = 8'h3F;
        run_move(8'h34, 8'h3F, B_NONE, gf);
        chk("no_eat_gen_cnt", gf, 32'd0);
        pix("len4_vacated", 8'h31, 8'h40, 1'b0);
        pix("len4_keep", 8'h32, 8'h40, 1'b1);

        // Second food grows to length 5.
        run_move(8'h35, 8'h3F, B_NONE, gf);
        chk("eat2_gen_cnt", gf, 32'd1);
        chk("eat2_score", {24'd0, bus.score}, 32'd2);
        bus.food_X = 8'h80; bus.food_Y = 8'h60;

        // Up, left, down: the down move lands on body segment 3.
        run_move(8'h35, 8'h3E, B_UP, gf);
        chk("after_eat_gen_cnt", gf, 32'd0);
        run_move(8'h34, 8'h3E, B_LEFT, gf);
        chk("pre_self_over", {31'd0, bus.game_over}, 32'd0);
        run_move(8'h34, 8'h3E, B_DOWN, gf);
        chk("self_over", {31'd0, bus.game_over}, 32'd1);
        chk("self_score", {24'd0, bus.score}, 32'd2);
        step(2 * MD);
        chk("self_over_hold", {31'd0, bus.game_over}, 32'd1);
        chk("over_gen", {31'd0, bus.gen_food}, 32'd0);
        chk_head("over_frozen", 8'h34, 8'h3E);
        pix("over_prnt", 8'h33, 8'h3F, 1'b1);

        // Reset mid-OVER acts without waiting for a clock edge.
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        step(1);
        rst = 1'b0;
        step(1);
        chk_reset_vals("rst2");

        // Wall: run right to x=90, then one more move hits the wall.
        bus.btn_right = 1'b1;
        step(1);
        bus.btn_right = 1'b0;
        for (int i = 0; i < 8'h60; i++)
            run_move(8'h31 + 8'(i), 8'h40, B_NONE, gf);
        chk("wall_pre_over", {31'd0, bus.game_over}, 32'd0);
        run_move(8'h90, 8'h40, B_NONE, gf);
        chk("wall_over", {31'd0, bus.game_over}, 32'd1);
        step(2 * MD);
        chk_head("wall_frozen", 8'h90, 8'h40);
        chk("wall_over_hold", {31'd0, bus.game_over}, 32'd1);
        chk("wall_score", {24'd0, bus.score}, 32'd0);
        chk("wall_gen", {31'd0, bus.gen_food}, 32'd0);
        pix("wall_prnt_8e", 8'h8E, 8'h40, 1'b1);
        pix("wall_prnt_8d", 8'h8D, 8'h40, 1'b0);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        chk_reset_vals("rst3");
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
